// File: rtl/uart_button_tx_pkg.sv
// Shared constants for the button/periodic UART message transmitter:
// baud default, message text ROM, message ids and ASCII helpers.
package uart_button_tx_pkg;

    localparam int CLKS_PER_BIT_DEF = 234;

    typedef enum logic [1:0] {
        MSG_BTN1  = 2'd0,
        MSG_BTN2  = 2'd1,
        MSG_HELLO = 2'd2
    } msg_id_e;

    localparam logic [4:0] BTN_LEN   = 5'd14;
    localparam logic [4:0] HELLO_LEN = 5'd24;

    localparam logic [111:0] BTN1_TEXT    = "BTN1 pressed\r\n";
    localparam logic [111:0] BTN2_TEXT    = "BTN2 pressed\r\n";
    localparam logic [143:0] HELLO_PREFIX = "Hello! Counter: 0x";

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [4:0] msg_len(input msg_id_e id);
        return (id == MSG_HELLO) ? HELLO_LEN : BTN_LEN;
    endfunction

    // Whole line left-aligned in 24 bytes so byte idx is a plain left shift away.
    function automatic logic [191:0] msg_line(input msg_id_e id, input logic [15:0] cnt);
        case (id)
            MSG_BTN1:  return {BTN1_TEXT, 80'h0};
            MSG_BTN2:  return {BTN2_TEXT, 80'h0};
            MSG_HELLO: return {HELLO_PREFIX,
                               nibble_to_ascii(cnt[15:12]), nibble_to_ascii(cnt[11:8]),
                               nibble_to_ascii(cnt[7:4]),   nibble_to_ascii(cnt[3:0]),
                               8'h0D, 8'h0A};
            default:   return '0;
        endcase
    endfunction

    function automatic logic [7:0] msg_byte(input msg_id_e id, input logic [4:0] idx,
                                            input logic [15:0] cnt);
        logic [191:0] line;
        line = msg_line(id, cnt) << {idx, 3'b000};
        return line[191:184];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first. ready is also raised in the last stop-bit
// cycle so a queued byte starts its start bit with no idle gap.
module uart_tx_byte
    import uart_button_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              busy;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bits_left;
    logic [8:0]        shift;
    logic              tx_q;
    logic              frame_end;

    assign frame_end = busy && (baud_cnt == '0) && (bits_left == 4'd0);
    assign ready     = ~busy | frame_end;
    assign tx        = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            baud_cnt  <= '0;
            bits_left <= 4'd0;
            shift     <= '0;
            tx_q      <= 1'b1;
        end else if (valid && ready) begin
            busy      <= 1'b1;
            baud_cnt  <= BAUD_LAST;
            bits_left <= 4'd9;
            shift     <= {1'b1, data};
            tx_q      <= 1'b0;
        end else if (busy) begin
            if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else if (bits_left == 4'd0) begin
                busy <= 1'b0;
                tx_q <= 1'b1;
            end else begin
                tx_q      <= shift[0];
                shift     <= {1'b1, shift[8:1]};
                bits_left <= bits_left - 4'd1;
                baud_cnt  <= BAUD_LAST;
            end
        end
    end

endmodule

// File: rtl/uart_button_tx.sv
// Button / periodic-timer driven ASCII line transmitter on one UART TX pin.
//   state    | meaning
//   ST_IDLE  | no line in flight; arbitrate pend1 > pend2 > pend_hello
//   ST_SEND  | feeding bytes of the latched line, back to IDLE after last stop bit
module uart_button_tx
    import uart_button_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEF,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int PERIOD_BITS     = 27,
    parameter int BLINK_BITS      = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn1,
    input  logic btn2,
    output logic led_r,
    output logic led_g,
    output logic led_b,
    output logic uart_tx
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn2, btn1};

    // press[i] pulses for one cycle when a debounced high->low transition is accepted.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]      sync;
        logic            level;
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync   <= 2'b11;
                level  <= 1'b1;
                db_cnt <= '0;
            end else begin
                sync <= {sync[0], btn_raw[i]};
                if (sync[1] == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level  <= sync[1];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        assign press[i] = (sync[1] != level) && (db_cnt == DB_LAST) && !sync[1];
    end

    logic [PERIOD_BITS-1:0] period_cnt;
    logic [BLINK_BITS-1:0]  blink_cnt;
    logic                   hello_tick;

    assign hello_tick = &period_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            blink_cnt  <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
            blink_cnt  <= blink_cnt + 1'b1;
        end
    end

    logic [0:0] state;
    logic       pend1, pend2, pend_hello;
    msg_id_e    msg_id;
    msg_id_e    next_id;
    logic [4:0] idx;
    logic [15:0] msg_cnt, cnt_lat;
    logic       clr1, clr2, clrh, start;
    logic       tx_valid, tx_ready, msg_done;
    logic [7:0] tx_data;

    always_comb begin
        clr1    = 1'b0;
        clr2    = 1'b0;
        clrh    = 1'b0;
        next_id = MSG_BTN1;
        if (state == ST_IDLE) begin
            if (pend1) begin
                clr1 = 1'b1;
            end else if (pend2) begin
                clr2    = 1'b1;
                next_id = MSG_BTN2;
            end else if (pend_hello) begin
                clrh    = 1'b1;
                next_id = MSG_HELLO;
            end
        end
    end

    assign start    = (state == ST_IDLE) && (pend1 || pend2 || pend_hello);
    assign tx_valid = (state == ST_SEND) && (idx != msg_len(msg_id));
    assign tx_data  = msg_byte(msg_id, idx, cnt_lat);
    assign msg_done = (state == ST_SEND) && (idx == msg_len(msg_id)) && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pend1      <= 1'b0;
            pend2      <= 1'b0;
            pend_hello <= 1'b0;
            msg_id     <= MSG_BTN1;
            idx        <= '0;
            msg_cnt    <= '0;
            cnt_lat    <= '0;
        end else begin
            // A new event in the same cycle its flag is consumed re-arms the flag.
            pend1      <= (pend1 & ~clr1) | press[0];
            pend2      <= (pend2 & ~clr2) | press[1];
            pend_hello <= (pend_hello & ~clrh) | hello_tick;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SEND;
                        msg_id  <= next_id;
                        idx     <= '0;
                        cnt_lat <= msg_cnt;
                    end
                end
                ST_SEND: begin
                    if (tx_valid && tx_ready) begin
                        idx <= idx + 5'd1;
                    end else if (msg_done) begin
                        state <= ST_IDLE;
                        if (msg_id == MSG_HELLO) msg_cnt <= msg_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (uart_tx)
    );

    assign led_r = ~blink_cnt[BLINK_BITS-1];
    assign led_g = ~blink_cnt[BLINK_BITS-2];
    assign led_b = (state != ST_SEND);

endmodule

// File: tb/tb_uart_button_tx.sv
// Bench for uart_button_tx: random button timing, UART line decoder and
// expected-line scoreboard built from the message texts.
module tb_uart_button_tx;

    localparam int CPB    = 10;
    localparam int DB     = 32;
    localparam int PB     = 15;
    localparam int BB     = 6;
    localparam int PERIOD = 1 << PB;
    localparam int FRAME  = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn1 = 1'b1;
    logic btn2 = 1'b1;
    logic led_r, led_g, led_b, uart_tx;

    uart_button_tx #(
        .CLKS_PER_BIT   (CPB),
        .DEBOUNCE_CYCLES(DB),
        .PERIOD_BITS    (PB),
        .BLINK_BITS     (BB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn1   (btn1),
        .btn2   (btn2),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected byte stream; eol_q marks the last byte of each line.
    logic [7:0] exp_q[$];
    bit         eol_q[$];
    int         line_t[$];
    int         fall_cnt = 0;
    int         line_cnt = 0;
    int         last_fall = 0;
    bit         prev_eol = 1'b1;
    bit         mon_en = 1'b0;
    bit         mbusy = 1'b0;

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
            eol_q.push_back(i == s.len() - 1);
        end
    endtask

    function automatic string hello_line(input int n);
        string hx, s;
        int d;
        hx = "0123456789ABCDEF";
        s  = "Hello! Counter: 0x";
        for (int k = 3; k >= 0; k--) begin
            d = (n >> (4 * k)) & 15;
            s = {s, hx.substr(d, d)};
        end
        return {s, "\r\n"};
    endfunction

    task automatic got_byte(input logic [7:0] b);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk("unexpected byte", 32'(b), 32'h100);
            prev_eol = 1'b1;
        end else begin
            e = exp_q.pop_front();
            prev_eol = eol_q.pop_front();
            chk("rx byte", 32'(b), 32'(e));
        end
    endtask

    // UART decoder sampling mid-bit on the falling clock edge.
    initial begin
        int moff;
        logic [7:0] mb;
        moff = 0;
        mb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                mbusy = 1'b0;
            end else if (!mbusy) begin
                if (uart_tx === 1'b0) begin
                    mbusy = 1'b1;
                    moff = 0;
                    fall_cnt++;
                    if (!prev_eol) chk("byte spacing", 32'(cyc - last_fall), 32'(FRAME));
                    else begin
                        line_t.push_back(cyc);
                        line_cnt++;
                    end
                    last_fall = cyc;
                end
            end else begin
                moff++;
                if (moff % CPB == CPB / 2) begin
                    chk("led_b while sending", 32'(led_b), 0);
                    if (moff / CPB == 0) chk("start bit", 32'(uart_tx), 0);
                    else if (moff / CPB <= 8) mb = {uart_tx, mb[7:1]};
                    else begin
                        chk("stop bit", 32'(uart_tx), 1);
                        mbusy = 1'b0;
                        got_byte(mb);
                    end
                end
            end
        end
    end

    task automatic set_btn(input int which, input logic v);
        if (which == 1) btn1 = v;
        else btn2 = v;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || led_b !== 1'b1 || mbusy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s drained in %0d cycles (limit %0d, %0d bytes left)",
                      tag, k, budget, exp_q.size()), 32'(k < budget), 1);
        chk({tag, " led_b idle"}, 32'(led_b), 1);
    endtask

    task automatic wait_lines(input int n, input int budget);
        int k = 0;
        while (line_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("line %0d started (have %0d) within %0d cycles", n, line_cnt, budget),
            32'(line_cnt >= n), 1);
    endtask

    task automatic chk_lat(input string tag, input int lat, input int lo, input int hi);
        chk($sformatf("%s %0d in [%0d,%0d]", tag, lat, lo, hi), 32'(lat >= lo && lat <= hi), 1);
    endtask

    int t_rel, t_press, base, hold, which, h0, f0;
    logic exp_bit;

    initial begin
        repeat (5) @(negedge clk);
        chk("reset uart_tx", 32'(uart_tx), 1);
        chk("reset led_r", 32'(led_r), 1);
        chk("reset led_g", 32'(led_g), 1);
        chk("reset led_b", 32'(led_b), 1);
        rst_n = 1'b1;
        t_rel = cyc;
        mon_en = 1'b1;

        // idle: blink counter tracks cycles since release, nothing transmitted
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(20, 150)) @(negedge clk);
            exp_bit = (((cyc - t_rel) >> (BB - 1)) & 1) == 0;
            chk("led_r blink", 32'(led_r), 32'(exp_bit));
            exp_bit = (((cyc - t_rel) >> (BB - 2)) & 1) == 0;
            chk("led_g blink", 32'(led_g), 32'(exp_bit));
        end
        chk("idle no frames", 32'(fall_cnt), 0);

        // single btn1 press, held for a random time
        base = line_cnt;
        hold = DB + $urandom_range(20, 2000);
        push_line("BTN1 pressed\r\n");
        set_btn(1, 1'b0);
        t_press = cyc;
        repeat (hold) @(negedge clk);
        set_btn(1, 1'b1);
        drain("btn1", 6000);
        chk("btn1 line count", 32'(line_cnt - base), 1);
        chk_lat("btn1 latency", line_t[base] - t_press, DB + 2, DB + 5);

        // btn2 pressed twice during the btn1 line: one btn2 line right after
        base = line_cnt;
        push_line("BTN1 pressed\r\n");
        set_btn(1, 1'b0);
        repeat (DB + $urandom_range(5, 50)) @(negedge clk);
        set_btn(1, 1'b1);
        wait_lines(base + 1, 200);
        repeat ($urandom_range(0, 300)) @(negedge clk);
        push_line("BTN2 pressed\r\n");
        for (int r = 0; r < 2; r++) begin
            set_btn(2, 1'b0);
            repeat (DB + 10) @(negedge clk);
            set_btn(2, 1'b1);
            repeat ($urandom_range(10, 30)) @(negedge clk);
        end
        drain("btn1+btn2", 8000);
        chk("btn1+btn2 line count", 32'(line_cnt - base), 2);
        chk_lat("inter-line gap", line_t[base + 1] - line_t[base], 14 * FRAME, 14 * FRAME + CPB);

        // both buttons in the same cycle
        base = line_cnt;
        push_line("BTN1 pressed\r\n");
        push_line("BTN2 pressed\r\n");
        hold = DB + $urandom_range(5, 400);
        btn1 = 1'b0;
        btn2 = 1'b0;
        t_press = cyc;
        repeat (hold) @(negedge clk);
        btn1 = 1'b1;
        btn2 = 1'b1;
        drain("both", 8000);
        chk("both line count", 32'(line_cnt - base), 2);
        chk_lat("both latency", line_t[base] - t_press, DB + 2, DB + 5);

        // bounce shorter than the debounce window, then a stable press
        base = line_cnt;
        which = $urandom_range(1, 2);
        for (int r = 0; r < int'($urandom_range(3, 8)); r++) begin
            set_btn(which, 1'b0);
            repeat ($urandom_range(1, DB - 4)) @(negedge clk);
            set_btn(which, 1'b1);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        push_line(which == 1 ? "BTN1 pressed\r\n" : "BTN2 pressed\r\n");
        set_btn(which, 1'b0);
        t_press = cyc;
        repeat (DB + 50) @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            set_btn(which, 1'b1);
            repeat ($urandom_range(1, 20)) @(negedge clk);
            set_btn(which, 1'b0);
            repeat ($urandom_range(1, DB - 4)) @(negedge clk);
        end
        set_btn(which, 1'b1);
        drain("bounce", 6000);
        chk("bounce line count", 32'(line_cnt - base), 1);
        chk_lat("bounce latency", line_t[base] - t_press, DB + 2, DB + 5);

        // first periodic line, with a btn1 press queued while it is sent
        while (cyc < t_rel + PERIOD - 200) @(negedge clk);
        base = line_cnt;
        push_line(hello_line(0));
        wait_lines(base + 1, 400);
        h0 = line_t[base];
        chk_lat("hello0 start", h0 - t_rel, PERIOD, PERIOD + 3);
        repeat ($urandom_range(0, 1500)) @(negedge clk);
        push_line("BTN1 pressed\r\n");
        set_btn(1, 1'b0);
        repeat (DB + 20) @(negedge clk);
        set_btn(1, 1'b1);
        drain("hello0+btn1", 8000);
        chk("hello0+btn1 line count", 32'(line_cnt - base), 2);

        // second periodic line exactly one period later, counter advanced
        while (cyc < t_rel + 2 * PERIOD - 200) @(negedge clk);
        base = line_cnt;
        push_line(hello_line(1));
        wait_lines(base + 1, 400);
        chk("hello period", 32'(line_t[base] - h0), 32'(PERIOD));
        drain("hello1", 6000);

        // reset in the middle of a byte's start bit abandons the line
        push_line("BTN2 pressed\r\n");
        f0 = fall_cnt;
        set_btn(2, 1'b0);
        repeat (DB + 10) @(negedge clk);
        set_btn(2, 1'b1);
        which = f0 + 1 + int'($urandom_range(2, 8));
        hold = 0;
        while (fall_cnt < which && hold < 3000) begin
            @(negedge clk);
            hold++;
        end
        chk($sformatf("byte %0d reached before reset", which), 32'(fall_cnt >= which), 1);
        repeat (CPB / 2) @(negedge clk);
        chk("tx in start bit", 32'(uart_tx), 0);
        rst_n = 1'b0;
        #1;
        chk("async reset uart_tx", 32'(uart_tx), 1);
        chk("async reset led_b", 32'(led_b), 1);
        exp_q.delete();
        eol_q.delete();
        prev_eol = 1'b1;
        f0 = fall_cnt;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        chk("no bytes after reset", 32'(fall_cnt - f0), 0);
        chk("led_b idle after reset", 32'(led_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
